// File: rtl/lru_pkg.sv
// rtl/lru_pkg.sv - shared op/state encodings and log2 helper for the LRU controller
package lru_pkg;

  localparam logic [1:0] OP_NONE  = 2'd0;
  localparam logic [1:0] OP_TOUCH = 2'd1;
  localparam logic [1:0] OP_QUERY = 2'd2;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// rtl/onehot_to_bin.sv - one-hot to binary encoder; lowest set bit wins, zero input gives 0
module onehot_to_bin
  import lru_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int WAY_BITS = log2(WIDTH)
) (
  input  logic [WIDTH-1:0]    i_onehot,
  output logic [WAY_BITS-1:0] o_bin
);

  always_comb begin
    o_bin = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_onehot[i]) o_bin = WAY_BITS'(i);
    end
  end

endmodule

// File: rtl/lru_ctrl.sv
// rtl/lru_ctrl.sv - LRU state array sequencer: init sweep, fill>hit>query arbitration,
// two-stage accept/access pipeline with same-index read-after-write stall
module lru_ctrl
  import lru_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int INDEX_BITS = 8,
  parameter int WAY_BITS   = log2(WIDTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  hit_valid,
  output logic                  hit_ready,
  input  logic [INDEX_BITS-1:0] hit_index,
  input  logic [WAY_BITS-1:0]   hit_way,
  input  logic                  fill_valid,
  output logic                  fill_ready,
  input  logic [INDEX_BITS-1:0] fill_index,
  input  logic [WAY_BITS-1:0]   fill_way,
  input  logic                  query_valid,
  output logic                  query_ready,
  input  logic [INDEX_BITS-1:0] query_index,
  output logic                  victim_valid,
  output logic [WAY_BITS-1:0]   victim_way,
  output logic                  init_done,
  output logic                  lru_reset,
  output logic [INDEX_BITS-1:0] lru_index,
  output logic [WAY_BITS-1:0]   lru_access,
  output logic                  lru_access_valid,
  input  logic [WIDTH-1:0]      lru_in
);

  state_t                r_state;
  state_t                w_state_next;
  logic [INDEX_BITS-1:0] r_count;
  logic [INDEX_BITS-1:0] r_last_index;
  logic [1:0]            r_s1_op;
  logic [INDEX_BITS-1:0] r_s1_index;
  logic [WAY_BITS-1:0]   r_s1_way;

  logic                  w_run;
  logic                  w_req;
  logic [1:0]            w_req_op;
  logic [INDEX_BITS-1:0] w_req_index;
  logic [WAY_BITS-1:0]   w_req_way;
  logic                  w_sel_fill;
  logic                  w_sel_hit;
  logic                  w_sel_query;
  logic                  w_hazard;
  logic                  w_grant;

  always_comb begin
    w_state_next = r_state;
    if (r_state == ST_INIT && (&r_count)) w_state_next = ST_RUN;
  end

  assign w_run = (r_state == ST_RUN) && !reset;

  always_comb begin
    w_req       = 1'b0;
    w_req_op    = OP_NONE;
    w_req_index = '0;
    w_req_way   = '0;
    w_sel_fill  = 1'b0;
    w_sel_hit   = 1'b0;
    w_sel_query = 1'b0;
    if (fill_valid) begin
      w_req       = 1'b1;
      w_req_op    = OP_TOUCH;
      w_req_index = fill_index;
      w_req_way   = fill_way;
      w_sel_fill  = 1'b1;
    end else if (hit_valid) begin
      w_req       = 1'b1;
      w_req_op    = OP_TOUCH;
      w_req_index = hit_index;
      w_req_way   = hit_way;
      w_sel_hit   = 1'b1;
    end else if (query_valid) begin
      w_req       = 1'b1;
      w_req_op    = OP_QUERY;
      w_req_index = query_index;
      w_sel_query = 1'b1;
    end
    // The array commits a touch at the end of S1, so a same-set request must wait one cycle
    w_hazard = (r_s1_op == OP_TOUCH) && (r_s1_index == w_req_index);
    w_grant  = w_run && w_req && !w_hazard;
  end

  assign fill_ready  = w_grant && w_sel_fill;
  assign hit_ready   = w_grant && w_sel_hit;
  assign query_ready = w_grant && w_sel_query;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_INIT;
      r_count      <= '0;
      r_last_index <= '0;
      r_s1_op      <= OP_NONE;
      r_s1_index   <= '0;
      r_s1_way     <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_INIT) begin
        r_count      <= r_count + 1'b1;
        r_last_index <= r_count;
      end
      if (w_grant) begin
        r_s1_op      <= w_req_op;
        r_s1_index   <= w_req_index;
        r_s1_way     <= w_req_way;
        r_last_index <= w_req_index;
      end else begin
        r_s1_op <= OP_NONE;
      end
    end
  end

  always_comb begin
    lru_index = r_last_index;
    if (reset) lru_index = '0;
    else if (r_state == ST_INIT) lru_index = r_count;
    else if (w_grant) lru_index = w_req_index;
  end

  assign lru_reset        = reset || (r_state == ST_INIT);
  assign init_done        = w_run;
  assign lru_access       = r_s1_way;
  assign lru_access_valid = !reset && (r_s1_op == OP_TOUCH);
  assign victim_valid     = !reset && (r_s1_op == OP_QUERY);

  onehot_to_bin #(
    .WIDTH   (WIDTH),
    .WAY_BITS(WAY_BITS)
  ) u_victim_enc (
    .i_onehot(lru_in),
    .o_bin   (victim_way)
  );

endmodule
